// File: rtl/fsk_modulator.sv
// Byte-framed binary FSK transmitter: optional mark preamble, start bit,
// 8 data bits LSB first, stop bit, each symbol a phase-continuous square tone.
module fsk_modulator #(
    parameter int unsigned HALF_PERIOD_0 = 50,
    parameter int unsigned HALF_PERIOD_1 = 73,
    parameter int unsigned BIT_CLKS      = 2920,
    parameter int unsigned PREAMBLE_BITS = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       fsk_out,
    output logic       busy,
    output logic       sym_out
);

    localparam logic [CNT_W-1:0] HP0_LAST = CNT_W'(HALF_PERIOD_0 - 1);
    localparam logic [CNT_W-1:0] HP1_LAST = CNT_W'(HALF_PERIOD_1 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CLKS - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           r_state,    w_state_n;
    logic [CNT_W-1:0] r_hp_cnt,   w_hp_cnt_n;
    logic [CNT_W-1:0] r_bit_cnt,  w_bit_cnt_n;
    logic [CNT_W-1:0] r_pre_cnt,  w_pre_cnt_n;
    logic [2:0]       r_bit_idx,  w_bit_idx_n;
    logic [7:0]       r_shift,    w_shift_n;
    logic             r_fsk,      w_fsk_n;
    logic             r_sym,      w_sym_n;
    logic             r_busy,     w_busy_n;
    logic             r_tx_ready, w_tx_ready_n;

    logic             w_accept;
    logic             w_bit_end;
    logic [CNT_W-1:0] w_hp_last;

    assign w_accept  = tx_valid && r_tx_ready;
    assign w_bit_end = (r_bit_cnt == BIT_LAST);
    // Half-period follows the symbol currently on air, so a new tone takes effect
    // from the first cycle of its symbol without clearing the phase counter.
    assign w_hp_last = r_sym ? HP1_LAST : HP0_LAST;

    always_comb begin
        w_state_n   = r_state;
        w_bit_cnt_n = w_bit_end ? '0 : r_bit_cnt + CNT_W'(1);
        w_pre_cnt_n = r_pre_cnt;
        w_bit_idx_n = r_bit_idx;
        w_shift_n   = r_shift;
        if (r_hp_cnt >= w_hp_last) begin
            w_hp_cnt_n = '0;
            w_fsk_n    = ~r_fsk;
        end else begin
            w_hp_cnt_n = r_hp_cnt + CNT_W'(1);
            w_fsk_n    = r_fsk;
        end

        case (r_state)
            S_IDLE: begin
                w_bit_cnt_n = '0;
                w_hp_cnt_n  = '0;
                w_fsk_n     = 1'b0;
                if (w_accept) begin
                    w_shift_n   = tx_data;
                    w_pre_cnt_n = '0;
                    w_bit_idx_n = 3'd0;
                    w_fsk_n     = 1'b1;
                    w_state_n   = (PREAMBLE_BITS != 0) ? S_PREAMBLE : S_START;
                end
            end
            S_PREAMBLE: begin
                if (w_bit_end) begin
                    if (r_pre_cnt == PRE_LAST) begin
                        w_pre_cnt_n = '0;
                        w_state_n   = S_START;
                    end else begin
                        w_pre_cnt_n = r_pre_cnt + CNT_W'(1);
                    end
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_bit_idx_n = 3'd0;
                    w_state_n   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_n   = {1'b0, r_shift[7:1]};
                    w_bit_idx_n = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_n = S_STOP;
                    end
                end
            end
            S_STOP: begin
                // A byte offered in the last stop cycle chains straight into START.
                if (w_bit_end) begin
                    if (w_accept) begin
                        w_shift_n   = tx_data;
                        w_bit_idx_n = 3'd0;
                        w_state_n   = S_START;
                    end else begin
                        w_hp_cnt_n = '0;
                        w_fsk_n    = 1'b0;
                        w_state_n  = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_n   = S_IDLE;
                w_bit_cnt_n = '0;
                w_hp_cnt_n  = '0;
                w_fsk_n     = 1'b0;
            end
        endcase

        w_busy_n     = (w_state_n != S_IDLE);
        w_tx_ready_n = (w_state_n == S_IDLE) ||
                       ((w_state_n == S_STOP) && (w_bit_cnt_n == BIT_LAST));
        case (w_state_n)
            S_PREAMBLE, S_STOP: w_sym_n = 1'b1;
            S_DATA:             w_sym_n = w_shift_n[0];
            default:            w_sym_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_hp_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_pre_cnt  <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_fsk      <= 1'b0;
            r_sym      <= 1'b0;
            r_busy     <= 1'b0;
            r_tx_ready <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_hp_cnt   <= w_hp_cnt_n;
            r_bit_cnt  <= w_bit_cnt_n;
            r_pre_cnt  <= w_pre_cnt_n;
            r_bit_idx  <= w_bit_idx_n;
            r_shift    <= w_shift_n;
            r_fsk      <= w_fsk_n;
            r_sym      <= w_sym_n;
            r_busy     <= w_busy_n;
            r_tx_ready <= w_tx_ready_n;
        end
    end

    assign tx_ready = r_tx_ready;
    assign fsk_out  = r_fsk;
    assign busy     = r_busy;
    assign sym_out  = r_sym;

endmodule

// File: tb/tb_fsk_modulator.sv
// Bench for fsk_modulator: default-parameter instance (a) and a short-timing
// instance (b); a scoreboard of sent bytes is checked against a waveform model.
module tb_fsk_modulator;

    typedef struct {
        logic [7:0] data;
        longint     t_push;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [7:0] tx_data_a, tx_data_b;
    logic       tx_valid_a, tx_valid_b;
    logic       tx_ready_a, tx_ready_b;
    logic       fsk_a, fsk_b, busy_a, busy_b, sym_a, sym_b;
    logic [1:0] fsk_s, busy_s, sym_s, rdy_s;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit [1:0] abort_req = 2'b00;
    bit       mon_en    = 1'b0;

    always #5 clk = ~clk;

    assign fsk_s  = {fsk_b, fsk_a};
    assign busy_s = {busy_b, busy_a};
    assign sym_s  = {sym_b, sym_a};
    assign rdy_s  = {tx_ready_b, tx_ready_a};

    fsk_modulator u_dut_a (
        .clk(clk), .rst(rst_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a), .fsk_out(fsk_a), .busy(busy_a), .sym_out(sym_a)
    );

    fsk_modulator #(
        .HALF_PERIOD_0(5), .HALF_PERIOD_1(7), .BIT_CLKS(70), .PREAMBLE_BITS(0), .CNT_W(16)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .fsk_out(fsk_b), .busy(busy_b), .sym_out(sym_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int q_size(input int id);
        return (id == 0) ? q_a.size() : q_b.size();
    endfunction

    task automatic q_push(input int id, input exp_t e);
        if (id == 0) q_a.push_back(e);
        else         q_b.push_back(e);
    endtask

    task automatic q_pop(input int id, output exp_t e);
        if (id == 0) e = q_a.pop_front();
        else         e = q_b.pop_front();
    endtask

    task automatic drive(input int id, input logic [7:0] d, input logic v);
        if (id == 0) begin tx_data_a = d; tx_valid_a = v; end
        else         begin tx_data_b = d; tx_valid_b = v; end
    endtask

    task automatic drop_valid(input int id);
        if (id == 0) tx_valid_a = 1'b0;
        else         tx_valid_b = 1'b0;
    endtask

    // Offer a byte, record it in the scoreboard on the cycle it will be accepted.
    task automatic send_byte(input int id, input logic [7:0] d, input bit keep);
        exp_t e;
        int   w;
        @(negedge clk);
        drive(id, d, 1'b1);
        w = 0;
        while (!rdy_s[id]) begin
            if (w >= 50000) begin
                check("accept_timeout", 0, 1);
                drop_valid(id);
                return;
            end
            w++;
            @(negedge clk);
        end
        e.data   = d;
        e.t_push = longint'($time);
        q_push(id, e);
        @(posedge clk);
        #1;
        if (!keep) drop_valid(id);
    endtask

    task automatic wait_idle(input int id, input int budget);
        int w;
        w = 0;
        repeat (2) @(negedge clk);
        while (busy_s[id] || q_size(id) != 0) begin
            if (w >= budget) begin
                check("idle_timeout", 0, 1);
                return;
            end
            w++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic measure_busy(input int id, input int budget, output int n);
        int w;
        w = 0;
        n = 0;
        @(negedge clk);
        while (!busy_s[id]) begin
            if (w >= budget) begin
                check("busy_rise_timeout", 0, 1);
                return;
            end
            w++;
            @(negedge clk);
        end
        while (busy_s[id] && n <= budget) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic track_runs(input int id, input int budget, output int mn, output int mx);
        int   w, run;
        logic prev;
        w  = 0;
        mn = 1000;
        mx = 0;
        @(negedge clk);
        while (!busy_s[id]) begin
            if (w >= budget) begin
                check("run_rise_timeout", 0, 1);
                return;
            end
            w++;
            @(negedge clk);
        end
        prev = fsk_s[id];
        run  = 0;
        w    = 0;
        while (busy_s[id] && w < budget) begin
            if (fsk_s[id] == prev) begin
                run++;
            end else begin
                if (run < mn) mn = run;
                if (run > mx) mx = run;
                run  = 1;
                prev = fsk_s[id];
            end
            w++;
            @(negedge clk);
        end
    endtask

    // Pops a byte at each frame start and compares every cycle to the expected tone.
    task automatic monitor(input int id, input int hp0, input int hp1, input int bitc, input int preb);
        exp_t       e;
        int         m_hp, errs, nsym, h;
        logic       m_fsk, b, exp_rdy;
        bit         just_ended, chained, aborted;
        logic [7:0] dec;
        just_ended = 1'b0;
        m_hp       = 0;
        m_fsk      = 1'b0;
        nsym       = preb + 10;
        forever begin
            @(negedge clk);
            if (abort_req[id]) begin
                abort_req[id] = 1'b0;
                just_ended    = 1'b0;
                continue;
            end
            if (just_ended && q_size(id) == 0)
                check($sformatf("busy_fall_%0d", id), int'(busy_s[id]), 0);
            chained    = just_ended;
            just_ended = 1'b0;
            if (!busy_s[id]) continue;
            if (q_size(id) == 0) begin
                check($sformatf("unexpected_frame_%0d", id), 1, 0);
                while (busy_s[id]) @(negedge clk);
                continue;
            end
            q_pop(id, e);
            check($sformatf("start_latency_%0d", id), int'(longint'($time) - e.t_push), 10);
            if (!chained) begin
                m_fsk = 1'b1;
                m_hp  = 0;
            end
            dec     = 8'h00;
            aborted = 1'b0;
            for (int s = 0; s < nsym && !aborted; s++) begin
                if (s < preb)           b = 1'b1;
                else if (s == preb)     b = 1'b0;
                else if (s < preb + 9)  b = e.data[s - preb - 1];
                else                    b = 1'b1;
                errs = 0;
                for (int c = 0; c < bitc; c++) begin
                    if (s != 0 || c != 0) @(negedge clk);
                    if (abort_req[id]) begin
                        aborted = 1'b1;
                        break;
                    end
                    exp_rdy = (s == nsym - 1) && (c == bitc - 1);
                    if (fsk_s[id] !== m_fsk || sym_s[id] !== b ||
                        busy_s[id] !== 1'b1 || rdy_s[id] !== exp_rdy) errs++;
                    if (c == bitc / 2 && s > preb && s < preb + 9)
                        dec[s - preb - 1] = sym_s[id];
                    h = b ? hp1 : hp0;
                    if (m_hp >= h - 1) begin
                        m_fsk = ~m_fsk;
                        m_hp  = 0;
                    end else begin
                        m_hp++;
                    end
                end
                if (!aborted) check($sformatf("wave_%0d_sym%0d", id, s), errs, 0);
            end
            if (aborted) begin
                abort_req[id] = 1'b0;
                continue;
            end
            check($sformatf("byte_%0d", id), int'(dec), int'(e.data));
            just_ended = 1'b1;
        end
    endtask

    initial begin
        wait (mon_en);
        monitor(0, 50, 73, 2920, 2);
    end

    initial begin
        wait (mon_en);
        monitor(1, 5, 7, 70, 0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, mn, mx, errs;
        rst_a = 1'b1; rst_b = 1'b1;
        tx_data_a = 8'h00; tx_data_b = 8'h00;
        tx_valid_a = 1'b0; tx_valid_b = 1'b0;

        // Reset values, then idle behaviour
        @(negedge clk);
        @(negedge clk);
        check("rst_vals_a", int'({fsk_a, busy_a, sym_a, tx_ready_a}), 0);
        check("rst_vals_b", int'({fsk_b, busy_b, sym_b, tx_ready_b}), 0);
        rst_a = 1'b0; rst_b = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("ready_after_rst_a", int'(tx_ready_a), 1);
        check("ready_after_rst_b", int'(tx_ready_b), 1);
        errs = 0;
        repeat (100) begin
            if (fsk_a || busy_a || !tx_ready_a || fsk_b || busy_b || !tx_ready_b) errs++;
            @(negedge clk);
        end
        check("idle_100", errs, 0);

        // Default parameters, single byte with preamble
        fork
            send_byte(0, 8'hA5, 1'b0);
            measure_busy(0, 40000, n);
        join
        check("busy_len_a", n, 35040);
        wait_idle(0, 1000);

        // Back-to-back frames held on tx_valid
        fork
            begin
                send_byte(1, 8'h3C, 1'b1);
                send_byte(1, 8'hFF, 1'b0);
            end
            measure_busy(1, 5000, n);
        join
        check("busy_len_b2b", n, 1400);
        wait_idle(1, 1000);

        // Half-period bounds across symbol boundaries
        fork
            send_byte(1, 8'h01, 1'b0);
            track_runs(1, 5000, mn, mx);
        join
        check("min_half_period", mn, 5);
        check("max_half_period", mx, 7);
        wait_idle(1, 1000);

        // Reset in the middle of data bit 3
        send_byte(1, 8'h5A, 1'b0);
        repeat (310) @(negedge clk);
        abort_req[1] = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        check("midrst_fsk", int'(fsk_b), 0);
        check("midrst_busy", int'(busy_b), 0);
        rst_b = 1'b0;
        @(negedge clk);
        check("midrst_ready", int'(tx_ready_b), 1);
        send_byte(1, 8'hC3, 1'b0);
        wait_idle(1, 2000);

        // tx_valid pulses while busy are ignored
        send_byte(1, 8'h96, 1'b0);
        for (int k = 0; k < 3; k++) begin
            repeat (150) @(negedge clk);
            check("ready_while_busy", int'(tx_ready_b), 0);
            tx_data_b  = 8'h00;
            tx_valid_b = 1'b1;
            @(negedge clk);
            tx_valid_b = 1'b0;
        end
        wait_idle(1, 2000);
        errs = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy_b) errs++;
        end
        check("no_spurious_frame", errs, 0);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
